// File: rtl/imm_gen_stage.sv
// Immediate-generation pipeline stage: decodes the RV immediate on the input side,
// then holds it in a 2-entry (output + skid) buffer. Optional macro: IMMGEN_CSR_EN.
module imm_gen_stage #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_type,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [2:0] TY_I    = 3'd0;
    localparam logic [2:0] TY_S    = 3'd1;
    localparam logic [2:0] TY_B    = 3'd2;
    localparam logic [2:0] TY_U    = 3'd3;
    localparam logic [2:0] TY_J    = 3'd4;
    localparam logic [2:0] TY_NONE = 3'd5;
    localparam logic [2:0] TY_Z    = 3'd6;
    localparam bit         IS_RV64 = (XLEN == 32'd64);

    logic [31:0]      dec_imm32_s;
    logic [XLEN-1:0]  dec_imm_s;
    logic [2:0]       dec_type_s;
    logic             dec_ill_s;
    logic             accept_s;
    logic             handoff_s;

    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_imm_q, out_imm_d;
    logic [2:0]       out_type_q, out_type_d;
    logic             out_illegal_q, out_illegal_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
    logic [2:0]       skid_type_q, skid_type_d;
    logic             skid_illegal_q, skid_illegal_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
    logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

    // Input-side decode: every format is first built as a 32-bit value, then sign-extended.
    always_comb begin
        dec_imm32_s = 32'd0;
        dec_type_s  = TY_NONE;
        dec_ill_s   = 1'b0;
        if (in_instr[1:0] != 2'b11) begin
            dec_ill_s = 1'b1;
        end else begin
            case (in_instr[6:0])
                7'b0000011, 7'b0010011, 7'b1100111: begin
                    dec_type_s  = TY_I;
                    dec_imm32_s = {{20{in_instr[31]}}, in_instr[31:20]};
                end
                7'b0011011: begin
                    if (IS_RV64) begin
                        dec_type_s  = TY_I;
                        dec_imm32_s = {{20{in_instr[31]}}, in_instr[31:20]};
                    end else begin
                        dec_ill_s = 1'b1;
                    end
                end
                7'b0100011: begin
                    dec_type_s  = TY_S;
                    dec_imm32_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                end
                7'b1100011: begin
                    dec_type_s  = TY_B;
                    dec_imm32_s = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                                   in_instr[11:8], 1'b0};
                end
                7'b1101111: begin
                    dec_type_s  = TY_J;
                    dec_imm32_s = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                                   in_instr[30:21], 1'b0};
                end
                7'b0110111, 7'b0010111: begin
                    dec_type_s  = TY_U;
                    dec_imm32_s = {in_instr[31:12], 12'd0};
                end
                7'b0110011, 7'b0001111: begin
                    dec_type_s = TY_NONE;
                end
                7'b0111011: begin
                    if (IS_RV64) begin
                        dec_type_s = TY_NONE;
                    end else begin
                        dec_ill_s = 1'b1;
                    end
                end
                7'b1110011: begin
`ifdef IMMGEN_CSR_EN
                    if (in_instr[14]) begin
                        dec_type_s  = TY_Z;
                        dec_imm32_s = {27'd0, in_instr[19:15]};
                    end else begin
                        dec_type_s = TY_NONE;
                    end
`else
                    dec_type_s = TY_NONE;
`endif
                end
                default: begin
                    dec_ill_s = 1'b1;
                end
            endcase
        end
        // Zimm has bit 31 clear, so sign extension leaves it zero-extended.
        dec_imm_s = XLEN'($signed(dec_imm32_s));
    end

    assign accept_s  = in_valid & ~skid_valid_q;
    assign handoff_s = out_valid_q & out_ready;

    // Next-state for the output register, skid entry and illegal counter.
    always_comb begin
        out_valid_d    = out_valid_q;
        out_imm_d      = out_imm_q;
        out_type_d     = out_type_q;
        out_illegal_d  = out_illegal_q;
        out_tag_d      = out_tag_q;
        skid_valid_d   = skid_valid_q;
        skid_imm_d     = skid_imm_q;
        skid_type_d    = skid_type_q;
        skid_illegal_d = skid_illegal_q;
        skid_tag_d     = skid_tag_q;
        illegal_cnt_d  = illegal_cnt_q;

        if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_valid_d   = 1'b1;
                out_imm_d     = skid_imm_q;
                out_type_d    = skid_type_q;
                out_illegal_d = skid_illegal_q;
                out_tag_d     = skid_tag_q;
                skid_valid_d  = 1'b0;
            end else if (accept_s) begin
                out_valid_d   = 1'b1;
                out_imm_d     = dec_imm_s;
                out_type_d    = dec_type_s;
                out_illegal_d = dec_ill_s;
                out_tag_d     = in_tag;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            // Output is stalled: a newly accepted entry parks in the skid slot.
            if (accept_s) begin
                skid_valid_d   = 1'b1;
                skid_imm_d     = dec_imm_s;
                skid_type_d    = dec_type_s;
                skid_illegal_d = dec_ill_s;
                skid_tag_d     = in_tag;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end

        if (handoff_s && out_illegal_q && (illegal_cnt_q != {CNT_W{1'b1}})) begin
            illegal_cnt_d = illegal_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            illegal_cnt_d = illegal_cnt_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q    <= 1'b0;
            out_imm_q      <= {XLEN{1'b0}};
            out_type_q     <= TY_NONE;
            out_illegal_q  <= 1'b0;
            out_tag_q      <= {TAG_W{1'b0}};
            skid_valid_q   <= 1'b0;
            skid_imm_q     <= {XLEN{1'b0}};
            skid_type_q    <= TY_NONE;
            skid_illegal_q <= 1'b0;
            skid_tag_q     <= {TAG_W{1'b0}};
            illegal_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            out_valid_q    <= out_valid_d;
            out_imm_q      <= out_imm_d;
            out_type_q     <= out_type_d;
            out_illegal_q  <= out_illegal_d;
            out_tag_q      <= out_tag_d;
            skid_valid_q   <= skid_valid_d;
            skid_imm_q     <= skid_imm_d;
            skid_type_q    <= skid_type_d;
            skid_illegal_q <= skid_illegal_d;
            skid_tag_q     <= skid_tag_d;
            illegal_cnt_q  <= illegal_cnt_d;
        end
    end

    assign in_ready    = ~skid_valid_q;
    assign out_valid   = out_valid_q;
    assign out_imm     = out_imm_q;
    assign out_type    = out_type_q;
    assign out_illegal = out_illegal_q;
    assign out_tag     = out_tag_q;
    assign illegal_cnt = illegal_cnt_q;

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
- Registered, parametrised immediate-generation pipeline stage between fetch and decode/execute.
- Accepts one 32-bit RV instruction per cycle on a valid/ready handshake and extracts the sign-extended immediate to XLEN.
- Classifies the immediate type and flags illegal opcodes.
- A 2-entry skid buffer gives full throughput with fully registered in_ready.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64.
- TAG_W, 5, width of the sideband tag (e.g. rd/ROB id) carried alongside each instruction.
- CNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  stage can accept; driven from a register (equals ~skid_valid).
- in_instr  input  32  instruction word.
- in_tag  input  TAG_W  sideband tag, passed through unchanged.
- out_valid  output  1  output register holds a result.
- out_ready  input  1  downstream accepts.
- out_imm  output  XLEN  extracted immediate.
- out_type  output  3  0=I, 1=S, 2=B, 3=U, 4=J, 5=NONE, 6=Z (CSR zimm).
- out_illegal  output  1  opcode unsupported or instr[1:0]!=2'b11.
- out_tag  output  TAG_W  tag of the output instruction.
- illegal_cnt  output  CNT_W  count of illegal instructions handed off downstream.

Behaviour:
- Reset (rst=1 at clk edge, including mid-transfer):
  - out_valid=0, skid_valid=0 (hence in_ready=1).
  - out_imm=0, out_type=5, out_illegal=0, out_tag=0, illegal_cnt=0.
  - Any in-flight or skid entry is discarded.
- Handshake: accept = in_valid & in_ready; hand-off = out_valid & out_ready. Latency is 1 cycle from accept to out_valid with no stall. Throughput is 1 per cycle.
- Output register update, when !out_valid | out_ready:
  - if skid_valid: load from skid; skid_valid<=0.
  - else if accept: load from input.
  - else: out_valid<=0.
- Skid write: when out_valid & !out_ready & accept, store the decoded entry in skid and set skid_valid<=1.
- Skid full: in_ready=0; in_instr/in_tag are ignored regardless of in_valid.
- Output stability: while out_valid & !out_ready, out_* are held stable.
- Decode is performed on the input side; skid and out registers hold the decoded fields.
- Immediate extraction by opcode (all values sign-extended from instr[31] to XLEN):
  - I-type, for 0000011, 0010011, 1100111, and 0011011 (XLEN=64 only): instr[31:20].
  - S-type (0100011): {instr[31:25], instr[11:7]}.
  - B-type (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - J-type (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - U-type (0110111, 0010111): {instr[31:12], 12'b0}, sign-extended for XLEN=64; exact 32 bits for XLEN=32.
  - NONE (0110011, 0111011 when XLEN=64, 0001111, 1110011): imm=0, legal.
- Illegal: any other opcode, 0011011/0111011 with XLEN=32, or instr[1:0]!=2'b11. Result: imm=0, type=5, illegal=1.
- illegal_cnt increments by 1 on each hand-off with out_illegal=1 and saturates at 2^CNT_W-1 (no wrap).
- Simultaneous hand-off and accept with skid empty: the new entry goes directly to the output register with no bubble.

Optional Feature:
- Macro: IMMGEN_CSR_EN.
- Defined: opcode 1110011 with funct3[2]=1 (CSRRWI/SI/CI) gives type=6 and imm = zero-extended instr[19:15]. Other SYSTEM funct3 values remain NONE.
- Undefined: all 1110011 instructions give type=5, imm=0, illegal=0.

Test Plan:
- XLEN=64, in_instr=0xFFF00093 with out_ready=1 -> one cycle later out_valid=1, out_imm=0xFFFFFFFFFFFFFFFF, out_type=0, tag echoed.
- in_instr=0x800000B7 -> XLEN=64: out_imm=0xFFFFFFFF80000000, type=3; XLEN=32: out_imm=0x80000000.
- in_instr=0xFE000EE3 -> out_imm=-4 (0xFFFFFFFFFFFFFFFC), type=2.
- Back-to-back stream of 4 instructions with out_ready held 0 for 2 cycles -> in_ready drops after the 2nd accept; all 4 are delivered in order with no loss or duplication; out_* stable while stalled.
- in_instr=0x0000007F, then 0x00000000, each handed off -> out_illegal=1 for both, illegal_cnt=2. With CNT_W=2 and 5 illegal hand-offs, illegal_cnt holds at 3.
- in_instr=0x3002D073 -> with IMMGEN_CSR_EN: type=6, imm=5; without it: type=5, imm=0, illegal=0. Asserting rst while stalled clears out_valid and skid, and in_ready=1 next cycle.
